// File: rtl/prod_accum.sv
// ============================================================================
// prod_accum : batches unsigned 16-bit products into a saturating 20-bit sum
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module prod_accum (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_valid,
  input  logic [15:0] p_data,
  output logic        p_ready,
  input  logic [7:0]  acc_len,
  input  logic        clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_data,
  output logic        out_ovf,
  output logic        busy
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] acc_q, acc_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [8:0]  len_q, len_d;
  logic        ovf_q, ovf_d;

  logic        w_xfer;
  logic [20:0] w_sum;
  logic [8:0]  w_len_eff;
  logic [8:0]  w_cnt_inc;

  assign p_ready   = (state_q == ACCUM) && !clr;
  assign w_xfer    = p_valid && p_ready;
  assign w_sum     = {1'b0, acc_q} + {5'd0, p_data};
  assign w_cnt_inc = cnt_q + 9'd1;
  // The batch length is captured on its first product, so the first
  // transfer must compare against the live acc_len rather than len_q.
  assign w_len_eff = (cnt_q == 9'd0) ?
                     ((acc_len == 8'd0) ? 9'd256 : {1'b0, acc_len}) : len_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (clr) begin
          acc_d = 20'd0;
          cnt_d = 9'd0;
          ovf_d = 1'b0;
        end else if (w_xfer) begin
          acc_d = w_sum[20] ? 20'hFFFFF : w_sum[19:0];
          ovf_d = ovf_q | w_sum[20];
          cnt_d = w_cnt_inc;
          len_d = w_len_eff;
          if (w_cnt_inc == w_len_eff) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = 20'd0;
          cnt_d   = 9'd0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= 20'd0;
      cnt_q   <= 9'd0;
      len_q   <= 9'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = (state_q == HOLD) ? acc_q : 20'd0;
  assign out_ovf   = (state_q == HOLD) && ovf_q;
  assign busy      = (cnt_q != 9'd0) || (state_q == HOLD);

endmodule

`default_nettype wire

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Ports SHALL be (clock and reset first):
  clk  input  1  single clock; all state updates on rising edge
  reset  input  1  synchronous, active-high
  p_valid  input  1  unsigned product from 8x8 multiplier is available
  p_data  input  16  unsigned product value
  p_ready  output  1  block accepts p_data this cycle
  acc_len  input  8  products per batch; 1..255 literal, 0 means 256
  clr  input  1  discard partial batch
  out_valid  output  1  batch result available
  out_ready  input  1  downstream accepts result
  out_data  output  20  batch sum, saturated
  out_ovf  output  1  batch sum saturated
  busy  output  1  a batch is in progress or a result is held
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-003 The block SHALL contain no parameters; all widths are fixed as listed.

Function
REQ-004 FSM states SHALL be ACCUM and HOLD only.
REQ-005 A product transfer SHALL occur on a rising edge where p_valid && p_ready.
REQ-006 p_ready SHALL equal (state==ACCUM) && !clr, combinationally.
REQ-007 acc_len SHALL be latched into len_q (9 bits, 0 maps to 256) on the first transfer of each batch (cnt==0); later acc_len changes SHALL NOT affect the open batch.
REQ-008 Per transfer: acc <= sat20(acc + p_data); cnt <= cnt+1 (9-bit cnt).
REQ-009 sat20 SHALL clamp any sum above 0xFFFFF to 0xFFFFF and set sticky ovf; ovf SHALL stay set until the batch is cleared.
REQ-010 On the transfer that makes cnt equal len_q, the FSM SHALL enter HOLD; out_valid SHALL rise the next cycle, with out_data = final acc and out_ovf = final ovf.
REQ-011 In HOLD, out_valid, out_data and out_ovf SHALL remain stable until out_valid && out_ready; p_ready SHALL be 0.
REQ-012 On the out handshake, acc, cnt and ovf SHALL be cleared and the FSM SHALL return to ACCUM; p_ready SHALL be 1 in the following cycle.
REQ-013 clr in ACCUM SHALL clear acc, cnt and ovf at the edge, and no transfer SHALL occur that cycle; clr in HOLD SHALL be ignored.
REQ-014 out_valid SHALL be 0 in ACCUM.
REQ-015 out_data and out_ovf SHALL read as 0 in ACCUM.
REQ-016 busy SHALL be (cnt!=0) || (state==HOLD).
REQ-017 Latency from the last transfer to out_valid SHALL be exactly 1 cycle.
REQ-018 Throughput SHALL be one transfer per cycle within a batch; there SHALL be at least one idle p_ready cycle between batches (the HOLD state).

Reset
REQ-019 Reset SHALL set state=ACCUM, acc=0, cnt=0, ovf=0 and len_q=0 on the next rising edge, from any state, including mid-batch and HOLD.
REQ-020 After that edge, out_valid=0, out_data=0, out_ovf=0, busy=0 and p_ready=1 (clr low).
REQ-021 Reset SHALL take priority over clr, over transfers and over the out handshake.

Verification
REQ-022 Basic batch: reset, acc_len=3, products 0x8480, 0x0001, 0x0010 on consecutive cycles -> out_valid high one cycle after the 3rd transfer, out_data=0x08491, out_ovf=0.
REQ-023 Saturation: acc_len=17, 17 products of 0xFFFF -> out_data=0xFFFFF, out_ovf=1; the next batch of acc_len=1 with 0x0002 -> out_data=0x00002, out_ovf=0.
REQ-024 Backpressure: complete a batch with out_ready low for 5 cycles -> out_valid and out_data stable and p_ready=0 throughout; handshake on cycle 6, then p_ready=1 and busy=0 the next cycle.
REQ-025 Clear mid-batch: acc_len=4, transfer 0x0100 and 0x0200, then clr=1 with p_valid=1 -> p_ready=0 that cycle; 4 further products of 0x0001 -> out_data=0x00004.
REQ-026 Boundary length: acc_len=0 with 256 products of 0x0001 -> out_valid only after the 256th transfer, out_data=0x00100; change acc_len to 5 mid-batch -> no effect.
REQ-027 Reset in HOLD with out_ready=0 -> out_valid=0, busy=0, p_ready=1 the next cycle; the held result is lost.
